// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared shot-clock state encoding, BCD digit type and decimal-to-BCD helper.
package scoreboard_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;
  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd2_t;
  function automatic bcd2_t to_bcd(input int unsigned v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_down_counter_2d.sv
// bcd_down_counter_2d: two-digit BCD down-counter with load, saturating decrement and zero flag.
module bcd_down_counter_2d
  import scoreboard_pkg::*;
#(
  parameter int RST_SEC = 24
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  bcd2_t i_load_val,
  input  logic  i_dec,
  output bcd2_t o_count,
  output logic  o_zero
);
  bcd2_t r_cnt;
  assign o_count = r_cnt;
  assign o_zero = (r_cnt == 8'h00);
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= to_bcd(RST_SEC);
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && !o_zero)
      r_cnt <= (r_cnt.ones == 4'd0) ? {r_cnt.tens - 4'd1, 4'd9} : {r_cnt.tens, r_cnt.ones - 4'd1};
  end
endmodule

// File: rtl/shot_clock_24.sv
// shot_clock_24: 24 s shot clock driven by a sampled 1 Hz wave; run/pause/reload FSM and buzzer timer.
// Define SHOT_CLOCK_14_EN to enable the btn_reload14 short reload to SHORT_SEC.
module shot_clock_24
  import scoreboard_pkg::*;
#(
  parameter int INIT_SEC  = 24,
  parameter int BUZZ_SECS = 3,
  parameter int SHORT_SEC = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz_in,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_reload,
  input  logic               btn_reload14,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               expired,
  output logic               buzzer
);
  logic       r_tick_d, r_running, r_expired, r_buzzer;
  logic [1:0] r_state, w_next, w_base;
  logic [3:0] r_buzz_cnt;
  logic       w_rise, w_r14, w_reload, w_tick_ok, w_expire, w_zero;
  bcd2_t      w_count, w_load_val;
`ifdef SHOT_CLOCK_14_EN
  assign w_r14 = btn_reload14;
  assign w_load_val = w_r14 ? to_bcd(SHORT_SEC) : to_bcd(INIT_SEC);
`else
  logic w_unused;
  assign w_unused = btn_reload14 ^ (SHORT_SEC != 0);
  assign w_r14 = 1'b0;
  assign w_load_val = to_bcd(INIT_SEC);
`endif
  assign w_rise = tick_1hz_in & ~r_tick_d;
  assign w_reload = w_r14 | btn_reload;
  // a tick only counts in RUN when no higher-priority button is active this cycle
  assign w_tick_ok = w_rise & ~w_reload & ~btn_pause & (r_state == ST_RUN) & ~w_zero;
  assign w_expire = w_tick_ok & (w_count == 8'h01);
  always_comb begin
    w_base = (w_reload && r_state == ST_EXPIRED) ? ST_IDLE : r_state;
    w_next = w_expire ? ST_EXPIRED :
             btn_pause ? ((w_base == ST_RUN) ? ST_PAUSE : w_base) :
             (btn_start && (w_base == ST_IDLE || w_base == ST_PAUSE)) ? ST_RUN : w_base;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tick_d <= 1'b0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_buzzer <= 1'b0;
      r_buzz_cnt <= 4'd0;
    end else begin
      r_state <= w_next;
      r_tick_d <= tick_1hz_in;
      r_running <= (w_next == ST_RUN);
      r_expired <= (w_next == ST_EXPIRED);
      if (w_reload) begin
        r_buzzer <= 1'b0;
        r_buzz_cnt <= 4'd0;
      end else if (w_expire) begin
        r_buzzer <= 1'b1;
        r_buzz_cnt <= 4'd0;
      end else if (r_state == ST_EXPIRED && w_rise && r_buzzer) begin
        r_buzz_cnt <= r_buzz_cnt + 4'd1;
        if (r_buzz_cnt + 4'd1 == 4'(BUZZ_SECS)) r_buzzer <= 1'b0;
      end
    end
  end
  bcd_down_counter_2d #(.RST_SEC(INIT_SEC)) u_cnt (
    .clk(clk),
    .rst(rst),
    .i_load(w_reload),
    .i_load_val(w_load_val),
    .i_dec(w_tick_ok),
    .o_count(w_count),
    .o_zero(w_zero)
  );
  assign sec_tens = w_count.tens;
  assign sec_ones = w_count.ones;
  assign running = r_running;
  assign expired = r_expired;
  assign buzzer = r_buzzer;
endmodule

// File: doc/shot_clock_24.md
Name: shot_clock_24

Overview:
Consumer end of the scoreboard clock-divider interface. It runs on the 100 MHz system clock and samples the divider's 1 Hz square wave (clk_1Hz) as data, not as a clock. It implements the 24-second shot clock: start/pause/reload control, a BCD countdown, an expiry flag and a timed buzzer. Its outputs feed the display scanner and the buzzer driver.

Parameters:
INIT_SEC, 24, reload value in seconds; range 1..99.
BUZZ_SECS, 3, number of 1 Hz rising edges the buzzer stays on after expiry; range 1..15.
SHORT_SEC, 14, short reload value in seconds; used only when SHOT_CLOCK_14_EN is defined.

Ports:
clk  in  1  100 MHz system clock
rst  in  1  synchronous, active-high reset
tick_1hz_in  in  1  1 Hz square wave from the divider; registered in the clk domain, so no synchroniser is needed
btn_start  in  1  single-cycle pulse from the debounce logic; start or resume
btn_pause  in  1  single-cycle pulse; pause
btn_reload  in  1  single-cycle pulse; load INIT_SEC
btn_reload14  in  1  single-cycle pulse; load SHORT_SEC (ignored unless the macro is defined)
sec_tens  out  4  BCD tens digit
sec_ones  out  4  BCD ones digit
running  out  1  high in RUN
expired  out  1  high in EXPIRED
buzzer  out  1  buzzer enable

Behaviour:
- Only clk is used as a clock. Reset is synchronous and active-high: it acts on a rising clk edge while rst=1.
- Reset values: state=IDLE, count=INIT_SEC (tens/ones in BCD), running=0, expired=0, buzzer=0, tick_d=0, buzz_cnt=0.
- Edge detect:
  - tick_d <= tick_1hz_in on every clk edge.
  - tick_rise = tick_1hz_in & ~tick_d.
  - The count updates on the clk edge where tick_rise=1. Outputs are registered, so the display changes one cycle after tick_1hz_in rises.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN:
    - pause -> PAUSE.
    - tick_rise with count>1 -> count-1.
    - tick_rise with count==1 -> count=0, go to EXPIRED, expired=1, buzzer=1, buzz_cnt=0.
  - PAUSE: start -> RUN. Ticks are ignored.
  - EXPIRED:
    - Each tick_rise increments buzz_cnt; when buzz_cnt reaches BUZZ_SECS, buzzer=0.
    - start and pause are ignored. Only a reload leaves this state.
- Decrement is in BCD: ones==0 -> ones=9 and tens-1; otherwise ones-1. The count never wraps below 00.
- Reload:
  - Loads count=INIT_SEC and clears expired, buzzer and buzz_cnt.
  - Next state: RUN stays RUN; PAUSE stays PAUSE; EXPIRED goes to IDLE; IDLE stays IDLE.
  - A tick_rise in the same cycle as a reload is discarded.
- Priority within one cycle: rst > reload14 > reload > pause > start > tick_rise.
  - reload + start together -> count=INIT_SEC, state=RUN.
  - pause + start together -> PAUSE.
  - pause + tick_rise together in RUN -> PAUSE, count unchanged.
- Output registers: running = (state==RUN); expired = (state==EXPIRED).
- The first decrement after start occurs at the next 1 Hz rising edge, i.e. 0 to 1 s later. This is accepted behaviour.
- Reset mid-count or mid-buzz returns everything to the reset values within one cycle.

Optional Feature:
SHOT_CLOCK_14_EN
- Defined: btn_reload14 loads SHORT_SEC, with the same state and flag effects as btn_reload. It has priority over btn_reload if both arrive together.
- Undefined: btn_reload14 is left unconnected inside the block, and SHORT_SEC has no effect.

Decomposition:
- Shared package scoreboard_pkg holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3;
  - the BCD digit width (4);
  - a function that converts a decimal constant to tens/ones.
- One natural sub-module: bcd_down_counter_2d, a two-digit BCD down-counter with load, decrement and zero flag. The FSM, edge detect and buzzer timer stay at the top level.

Test Plan:
1. Reset, then start, then 24 tick_1hz_in rising edges -> digits step 24, 23, ..., 01, 00. expired=1 and buzzer=1 on the 24th edge; running=0.
2. After expiry, 3 more rising edges -> buzzer drops to 0 on the 3rd edge; expired stays 1. btn_start has no effect. btn_reload -> 24, IDLE, expired=0.
3. Start, 5 edges (count=19), pause, 4 edges -> count holds at 19. Start, 1 edge -> 18.
4. btn_reload and btn_start in the same cycle from count 07 while paused -> count=24 and running=1 next cycle. A rising edge in that same cycle does not decrement.
5. At count 10, a rising edge -> 09 (BCD borrow). Assert rst mid-run -> 24, IDLE, all flags 0 on the next edge.
6. With SHOT_CLOCK_14_EN defined: btn_reload14 during RUN at 20 -> 14, still running. btn_reload14 and btn_reload together -> 14.
